fetch_stage: RTL and testbench

Instruction fetch stage for the pipelined rv32i core. It owns the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel. Returned instructions are buffered with their PC in a small queue and presented to decode over a valid/ready handshake. A redirect from the branch evaluator flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the rv32i fetch stage.
package fetch_pkg;
    localparam int INSTR_BYTES = 4;
    localparam int PKG_XLEN    = 32;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [31:0]         instruction;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head_data is the oldest entry, valid whenever !empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign count     = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_reg + AW'(do_pop);
            wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
            count_reg  <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited in-order imem requests, PC-tagged fetch queue, redirect flush.
// Optional build macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instruction,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus_four
);
    localparam int LW          = $clog2(FIFO_DEPTH) + 1;
    localparam int DW          = LW + 1;
    localparam int DISCARD_MAX = 2 * FIFO_DEPTH;

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [LW-1:0]   live_reg, live_next;
    logic [DW-1:0]   discard_reg, discard_next;
    logic [DW-1:0]   discard_sum;
    logic [DW-1:0]   credit_used;

    logic            req_fire;
    logic            resp_take;
    logic            bypass;
    logic            q_push;
    logic            q_pop;
    logic            q_empty;
    logic            q_full;
    logic [LW-1:0]   q_count;
    fetch_entry_t    q_head;
    fetch_entry_t    resp_entry;
    fetch_entry_t    out_entry;
    logic [XLEN-1:0] tag_pc;
    logic            tag_empty;
    logic            tag_full;
    logic [LW-1:0]   tag_count;
    logic            unused_fifo_status;

    assign credit_used    = DW'(q_count) + DW'(live_reg);
    assign imem_req_valid = reset && !redirect && (credit_used < DW'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Only responses not owed to a pre-redirect request reach the queue.
    assign resp_take  = reset && imem_resp_valid && !redirect && (discard_reg == '0);
    assign resp_entry = '{pc: tag_pc, instruction: imem_resp_data};

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_take && q_empty;
`else
    assign bypass = 1'b0;
`endif

    assign out_entry       = bypass ? resp_entry : q_head;
    assign if_valid        = !q_empty || bypass;
    assign if_instruction  = out_entry.instruction;
    assign if_pc           = out_entry.pc;
    assign if_pc_plus_four = if_pc + XLEN'(INSTR_BYTES);
    assign q_push          = resp_take && !(bypass && if_ready);
    assign q_pop           = !q_empty && if_ready && !redirect;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (q_push),
        .push_data (resp_entry),
        .pop       (q_pop),
        .head_data (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    // Holds the PC of every live request; popped in order as responses are accepted.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (req_fire),
        .push_data (fetch_pc_reg),
        .pop       (resp_take),
        .head_data (tag_pc),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (tag_count)
    );

    assign unused_fifo_status = ^{q_full, tag_empty, tag_full, tag_count};

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        live_next     = live_reg;
        discard_next  = discard_reg;
        discard_sum   = '0;
        if (redirect) begin
            // Every outstanding request becomes stale; a response arriving now retires one of them.
            discard_sum   = discard_reg + DW'(live_reg) - DW'(imem_resp_valid);
            discard_next  = (discard_sum > DW'(DISCARD_MAX)) ? DW'(DISCARD_MAX) : discard_sum;
            live_next     = '0;
            fetch_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + XLEN'(INSTR_BYTES);
            end
            live_next = live_reg + LW'(req_fire) - LW'(resp_take);
            if (imem_resp_valid && discard_reg != '0) begin
                discard_next = discard_reg - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_reg <= RESET_PC;
            live_reg     <= '0;
            discard_reg  <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            live_reg     <= live_next;
            discard_reg  <= discard_next;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: fixed-latency memory model, PC-stream scoreboard, redirect vectors.
module tb_fetch_stage;
    localparam int XLEN = 32;

`ifdef FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_four;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN       (XLEN),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc),
        .if_pc_plus_four (if_pc_plus_four)
    );

    int errors = 0;
    int checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0000_0013;
    endfunction

    // Memory model: accepts every ready request, answers in order after mem_lat cycles.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    int          mem_lat = 1;
    int          ncyc = 0;
    int          acc_count = 0;
    logic [31:0] last_acc_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            ncyc++;
            if (!reset) begin
                pend_q.delete();
                imem_resp_valid = 1'b0;
            end else if (pend_q.size() > 0 && pend_q[0].due == ncyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
            #1;
            if (reset && imem_req_valid && imem_req_ready) begin
                pend_q.push_back('{addr: imem_req_addr, due: ncyc + mem_lat});
                acc_count++;
                last_acc_addr = imem_req_addr;
            end
        end
    end

    // Scoreboard: program-order PCs expected at decode since the last reset/redirect.
    logic [31:0] exp_q[$];

    task automatic start_stream(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(pc + 32'(i * 4));
    endtask

    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            #3;
            if (reset && !redirect && if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deliver_unexpected pc=%h required=none", if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    $display("deliver pc=%h instr=%h pc4=%h", if_pc, if_instruction, if_pc_plus_four);
                    check32("deliver_pc", if_pc, exp_pc);
                    check32("deliver_instr", if_instruction, mem_word(exp_pc));
                    check32("deliver_pc4", if_pc_plus_four, exp_pc + 32'd4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Leaves the caller at the negedge of the first cycle with reset high.
    task automatic do_reset(input int lat);
        @(negedge clk);
        reset = 1'b0;
        redirect = 1'b0;
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        mem_lat = lat;
        exp_q.delete();
        @(negedge clk);
        #3;
        check32("reset_if_valid", 32'(if_valid), 32'd0);
        check32("reset_req_valid", 32'(imem_req_valid), 32'd0);
        check32("reset_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        start_stream(32'h0);
    endtask

    task automatic wait_if_valid(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_pc4);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #3;
            if (if_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_timeout if_valid=0 after 20 cycles required=1", name);
        end else begin
            check32({name, "_pc"}, if_pc, exp_pc);
            check32({name, "_pc4"}, if_pc_plus_four, exp_pc4);
        end
    endtask

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc4;
    } redir_vec_t;

    redir_vec_t vecs[4];

    initial begin
        int a0;
        bit done;

        vecs[0] = '{32'h0000_0043, 32'h0000_0040, 32'h0000_0044};
        vecs[1] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008};
        vecs[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};

        // Streaming with 1-cycle memory and decode always ready
        do_reset(1);
        #3;
        check32("p0_req_valid", 32'(imem_req_valid), 32'd1);
        check32("p0_req_addr", imem_req_addr, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #3;
            check32("stream_req_valid", 32'(imem_req_valid), 32'd1);
            check32("stream_req_addr", imem_req_addr, 32'(k * 4));
            if (k == 1) check32("first_resp_if_valid", 32'(if_valid), BYPASS ? 32'd1 : 32'd0);
            if (k == 2) begin
                check32("second_cycle_if_valid", 32'(if_valid), 32'd1);
                check32("second_cycle_if_pc", if_pc, BYPASS ? 32'h4 : 32'h0);
            end
        end

        // Decode stalled: credits cap in-flight + queued at four
        do_reset(1);
        if_ready = 1'b0;
        a0 = acc_count;
        repeat (8) @(negedge clk);
        #3;
        check32("stall_req_count", 32'(acc_count - a0), 32'd4);
        check32("stall_last_addr", last_acc_addr, 32'hC);
        check32("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check32("stall_if_valid", 32'(if_valid), 32'd1);
        @(negedge clk);
        if_ready = 1'b1;
        #3;
        check32("resume_head_pc", if_pc, 32'h0);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            #3;
            if (acc_count - a0 >= 5) done = 1'b1;
        end
        check32("resume_fifth_req_seen", 32'(done), 32'd1);
        check32("resume_addr", last_acc_addr, 32'h10);

        // 3-cycle memory, redirect with two requests live
        do_reset(3);
        repeat (2) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        start_stream(32'h40);
        #3;
        check32("redir_cycle_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        check32("redir_next_req_valid", 32'(imem_req_valid), 32'd1);
        check32("redir_next_req_addr", imem_req_addr, 32'h40);
        wait_if_valid("redir_first", 32'h40, 32'h44);

        // Redirect target alignment and wrap, still on 3-cycle memory
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            redirect = 1'b1;
            redirect_pc = vecs[v].rpc;
            start_stream(vecs[v].exp_addr);
            #3;
            check32("vec_redir_req_valid", 32'(imem_req_valid), 32'd0);
            @(negedge clk);
            redirect = 1'b0;
            #3;
            check32("vec_req_valid", 32'(imem_req_valid), 32'd1);
            check32("vec_req_addr", imem_req_addr, vecs[v].exp_addr);
            wait_if_valid("vec_first", vecs[v].exp_addr, vecs[v].exp_pc4);
        end

        // Redirect coinciding with a response while decode is ready
        do_reset(1);
        if_ready = 1'b0;
        repeat (2) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        if_ready = 1'b1;
        start_stream(32'h200);
        #3;
        check32("coinc_if_valid", 32'(if_valid), 32'd1);
        check32("coinc_head_pc", if_pc, 32'h0);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        check32("coinc_after_if_valid", 32'(if_valid), 32'd0);
        check32("coinc_after_req_addr", imem_req_addr, 32'h200);
        wait_if_valid("coinc_first", 32'h200, 32'h204);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
